// File: rtl/step_phase_sequencer_pkg.sv
// rtl/step_phase_sequencer_pkg.sv - shared state encoding and coil phase table
package step_phase_sequencer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Entry i sits at bits [4*i +: 4]; even indices are wave drive, odd are two-phase drive
   localparam logic [7:0][3:0] PHASE_TABLE = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

   localparam logic [3:0] COILS_OFF = 4'b0000;

endpackage

// File: rtl/step_phase_lut.sv
// rtl/step_phase_lut.sv - 3-bit phase index to 4-bit coil pattern lookup
module step_phase_lut
   import step_phase_sequencer_pkg::*;
(
   input  logic [2:0] idx,
   output logic [3:0] pattern
);

   assign pattern = PHASE_TABLE[idx];

endmodule

// File: rtl/step_phase_sequencer.sv
// rtl/step_phase_sequencer.sv - step-tick driven 4-coil phase sequencer with position tracking
module step_phase_sequencer
   import step_phase_sequencer_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int POS_W = 16
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stepTick,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    dir,
   input  logic                    halfStep,
   input  logic                    holdEnable,
   input  logic [CNT_W-1:0]        stepCount,
   output logic [3:0]              coils,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [CNT_W-1:0]        stepsLeft,
   output logic signed [POS_W-1:0] position
);

   state_t           state;
   logic [2:0]       idx;
   logic [2:0]       idx_nxt;
   logic [2:0]       idx_inc;
   logic [POS_W-1:0] pos_inc;
   logic             dir_q;
   logic             half_q;
   logic             step_en;
   logic [3:0]       pattern;

   // A step is only taken in RUN, and stop always beats a coincident tick
   assign step_en = (state == ST_RUN) && stepTick && !stop;
   assign idx_inc = half_q ? 3'd1 : 3'd2;
   assign pos_inc = half_q ? POS_W'(1) : POS_W'(2);

   // Next phase index; the 3-bit add/subtract gives the modulo-8 wrap for free
   always_comb begin
      idx_nxt = idx;
      if (step_en) begin
         idx_nxt = dir_q ? (idx + idx_inc) : (idx - idx_inc);
      end
   end

   // Lookup follows idx_nxt so the coil register sees the new entry on the stepping edge
   step_phase_lut u_lut (
      .idx     (idx_nxt),
      .pattern (pattern)
   );

   // Move FSM with all outputs registered; done/aborted default low to make them pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         idx       <= 3'd0;
         dir_q     <= 1'b0;
         half_q    <= 1'b0;
         coils     <= COILS_OFF;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         stepsLeft <= '0;
         position  <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            ST_IDLE: begin
               coils <= holdEnable ? pattern : COILS_OFF;
               if (start) begin
                  if (stepCount != '0) begin
                     state     <= ST_RUN;
                     busy      <= 1'b1;
                     stepsLeft <= stepCount;
                     dir_q     <= dir;
                     half_q    <= halfStep;
                     coils     <= pattern;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (stepTick) begin
                  idx       <= idx_nxt;
                  coils     <= pattern;
                  stepsLeft <= stepsLeft - CNT_W'(1);
                  position  <= dir_q ? (position + pos_inc) : (position - pos_inc);
                  if (stepsLeft == CNT_W'(1)) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_step_phase_sequencer.sv
// tb/tb_step_phase_sequencer.sv - randomized self-checking bench for step_phase_sequencer
module tb_step_phase_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stepTick, start, stop, dir, halfStep, holdEnable;
   logic [15:0] stepCount;
   logic [3:0]  coils;
   logic        busy, done, aborted;
   logic [15:0] stepsLeft;
   logic signed [15:0] position;

   int n_chk  = 0;
   int n_fail = 0;
   int tbl [8] = '{8, 12, 4, 6, 2, 3, 1, 9};
   int idx_m  = 0;
   int pos_m  = 0;

   step_phase_sequencer #(.CNT_W(16), .POS_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .stepTick   (stepTick),
      .start      (start),
      .stop       (stop),
      .dir        (dir),
      .halfStep   (halfStep),
      .holdEnable (holdEnable),
      .stepCount  (stepCount),
      .coils      (coils),
      .busy       (busy),
      .done       (done),
      .aborted    (aborted),
      .stepsLeft  (stepsLeft),
      .position   (position)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   function automatic int hold_coils(input bit h);
      return h ? tbl[idx_m] : 0;
   endfunction

   task automatic idle_cycle(input bit h);
      @(negedge clk);
      holdEnable = h;
      start      = 1'b0;
      stepTick   = 1'($urandom_range(0, 1));
      stop       = 1'($urandom_range(0, 1));
      sample();
      chk("idle_coils", {28'h0, coils}, hold_coils(h));
      chk("idle_flags", {29'h0, busy, done, aborted}, 0);
      chk("idle_pos", {16'h0, position}, pos_m & 32'hFFFF);
   endtask

   // One move: stop_at = k asserts stop with the k-th tick, 0 or >cnt means run to completion
   task automatic move(input int cnt, input bit d, input bit h, input int stop_at, input bit hold);
      int  inc;
      bit  ended;
      inc   = h ? 1 : 2;
      ended = 1'b0;
      @(negedge clk);
      start = 1'b1; dir = d; halfStep = h; stepCount = 16'(cnt);
      stepTick = 1'b0; stop = 1'b0; holdEnable = hold;
      sample();
      if (cnt == 0) begin
         chk("zero_flags", {29'h0, busy, done, aborted}, 32'b010);
         chk("zero_coils", {28'h0, coils}, hold_coils(hold));
         @(negedge clk);
         start = 1'b0;
         sample();
         chk("zero_post", {29'h0, busy, done, aborted}, 0);
         return;
      end
      chk("start_flags", {29'h0, busy, done, aborted}, 32'b100);
      chk("start_left", {16'h0, stepsLeft}, cnt);
      chk("start_coils", {28'h0, coils}, tbl[idx_m]);
      for (int k = 1; k <= cnt && !ended; k++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start      = 1'($urandom_range(0, 1));
            dir        = 1'($urandom_range(0, 1));
            halfStep   = 1'($urandom_range(0, 1));
            holdEnable = 1'($urandom_range(0, 1));
            stepCount  = 16'($urandom);
            stepTick   = 1'b0;
            stop       = 1'b0;
            sample();
            chk("gap_flags", {29'h0, busy, done, aborted}, 32'b100);
            chk("gap_left", {16'h0, stepsLeft}, cnt - k + 1);
            chk("gap_coils", {28'h0, coils}, tbl[idx_m]);
         end
         @(negedge clk);
         start    = 1'b0;
         stepTick = 1'b1;
         stop     = (k == stop_at);
         sample();
         if (k == stop_at) begin
            chk("abort_flags", {29'h0, busy, done, aborted}, 32'b011);
            chk("abort_left", {16'h0, stepsLeft}, cnt - k + 1);
            chk("abort_coils", {28'h0, coils}, tbl[idx_m]);
            chk("abort_pos", {16'h0, position}, pos_m & 32'hFFFF);
            ended = 1'b1;
         end else begin
            idx_m = (((idx_m + (d ? inc : -inc)) % 8) + 8) % 8;
            pos_m = pos_m + (d ? inc : -inc);
            chk("step_coils", {28'h0, coils}, tbl[idx_m]);
            chk("step_left", {16'h0, stepsLeft}, cnt - k);
            chk("step_pos", {16'h0, position}, pos_m & 32'hFFFF);
            chk("step_flags", {29'h0, busy, done, aborted}, (k == cnt) ? 32'b010 : 32'b100);
         end
      end
      @(negedge clk);
      stepTick = 1'b0; stop = 1'b0; start = 1'b0; holdEnable = hold;
      sample();
      chk("post_flags", {29'h0, busy, done, aborted}, 0);
      chk("post_coils", {28'h0, coils}, hold_coils(hold));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      stepTick = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
      halfStep = 1'b0; holdEnable = 1'b0; stepCount = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_coils", {28'h0, coils}, 0);
      chk("rst_flags", {29'h0, busy, done, aborted}, 0);
      chk("rst_left", {16'h0, stepsLeft}, 0);
      chk("rst_pos", {16'h0, position}, 0);
      @(negedge clk);
      rst = 1'b1;

      // full-step reverse from index 0 wraps through 6,4,2,0,6 to position -10
      move(5, 1'b0, 1'b0, 0, 1'b1);
      chk("rev_pos_final", {16'h0, position}, 32'hFFF6);

      // reset in the middle of a move discards it without a done pulse
      @(negedge clk);
      start = 1'b1; dir = 1'b1; halfStep = 1'b1; stepCount = 16'd10;
      sample();
      @(negedge clk);
      start = 1'b0; stepTick = 1'b1;
      sample();
      @(negedge clk);
      stepTick = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("midrst_coils", {28'h0, coils}, 0);
      chk("midrst_flags", {29'h0, busy, done, aborted}, 0);
      chk("midrst_pos", {16'h0, position}, 0);
      chk("midrst_left", {16'h0, stepsLeft}, 0);
      repeat (2) begin
         sample();
         chk("midrst_nodone", {31'h0, done}, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      idx_m = 0;
      pos_m = 0;

      move(3, 1'b1, 1'b1, 0, 1'b1);
      chk("fwd_pos_final", {16'h0, position}, 3);
      move(4, 1'b1, 1'b1, 2, 1'b1);
      move(0, 1'b1, 1'b1, 0, 1'b1);
      idle_cycle(1'b1);
      idle_cycle(1'b0);
      idle_cycle(1'b1);
      idle_cycle(1'b0);

      repeat (25) begin
         int cnt;
         cnt = $urandom_range(0, 7);
         move(cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, cnt + 3), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(1, 3)) idle_cycle(1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
